// File: rtl/adder_serial_acc.sv
// adder_serial_acc: digit-serial adder/subtractor with a persistent accumulator.
// Operands enter through a valid/ready handshake. Each RUN cycle adds DIGIT bits,
// starting at the LSB, through one DIGIT-wide carry chain. The result is held in
// DONE until a consumer handshake takes it.
module adder_serial_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] DMASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);

  if (WIDTH < 2) begin : g_bad_width
    $error("adder_serial_acc: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("adder_serial_acc: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11} op_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    dig;
  logic             acc_op;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT-1:0] ds;
  logic [DIGIT:0]   dc;
  logic [WIDTH-1:0] sum_nx;
  logic             last;
  int unsigned      sh;

  assign in_ready = ena & (state == IDLE);
  assign busy     = (state != IDLE);

  // One digit of the ripple chain, and the sum with that digit merged in.
  // Shifts are used instead of variable part-selects so the slice offset
  // needs no particular index width.
  always_comb begin
    sh     = 32'(dig) * 32'(DIGIT);
    da     = DIGIT'(opa >> sh);
    db     = DIGIT'(opb >> sh);
    ds     = '0;
    dc     = '0;
    dc[0]  = carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      ds[i]   = da[i] ^ db[i] ^ dc[i];
      dc[i+1] = (da[i] & db[i]) | (dc[i] & (da[i] ^ db[i]));
    end
    sum_nx = (sum & ~(DMASK << sh)) | (WIDTH'(ds) << sh);
    last   = (dig == LAST);
  end

  // Control FSM, datapath registers and registered result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      dig       <= '0;
      acc_op    <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_CLR) begin
              state     <= DONE;
              acc       <= '0;
              sum       <= '0;
              cout      <= 1'b0;
              ovf       <= 1'b0;
              zero      <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              state  <= RUN;
              dig    <= '0;
              carry  <= (op == OP_SUB);
              opa    <= (op == OP_ACC) ? acc : a;
              opb    <= (op == OP_SUB) ? ~b : b;
              acc_op <= (op == OP_ACC);
            end
          end
        end
        RUN: begin
          sum   <= sum_nx;
          carry <= dc[DIGIT];
          dig   <= dig + CW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= dc[DIGIT];
            ovf       <= dc[DIGIT] ^ dc[DIGIT-1];
            zero      <= (sum_nx == '0);
            if (acc_op) begin
              acc <= sum_nx;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial_acc.sv
// Testbench for adder_serial_acc. It drives a DIGIT=1 instance and a DIGIT=4
// instance through shared stimulus, gated by sel. Results are checked against a
// fixed vector table, against hand-written corner sequences and against an
// arithmetic reference model under random stimulus.
module tb_adder_serial_acc;

  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, out_ready, sel;
  logic [1:0] op;
  logic [7:0] a, b;

  logic       in_ready1, out_valid1, cout1, ovf1, zero1, busy1;
  logic [7:0] sum1;
  logic       in_ready4, out_valid4, cout4, ovf4, zero4, busy4;
  logic [7:0] sum4;

  logic       obs_in_ready, obs_out_valid, obs_cout, obs_ovf, obs_zero, obs_busy;
  logic [7:0] obs_sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] acc_m [2];

  always #5 clk = ~clk;

  adder_serial_acc #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1), .busy(busy1)
  );

  adder_serial_acc #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid & sel), .in_ready(in_ready4),
    .op(op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4), .busy(busy4)
  );

  assign obs_in_ready  = sel ? in_ready4  : in_ready1;
  assign obs_out_valid = sel ? out_valid4 : out_valid1;
  assign obs_sum       = sel ? sum4       : sum1;
  assign obs_cout      = sel ? cout4      : cout1;
  assign obs_ovf       = sel ? ovf4       : ovf1;
  assign obs_zero      = sel ? zero4      : zero1;
  assign obs_busy      = sel ? busy4      : busy1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input int s, input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] es, output logic ec, output logic ev, output logic ez);
    int ua, ub, sa, sb, r, rs;
    logic [7:0] x;
    x  = (o == 2'b10) ? acc_m[s] : av;
    ua = int'(x);
    ub = int'(bv);
    sa = int'($signed(x));
    sb = int'($signed(bv));
    es = 8'h00; ec = 1'b0; ev = 1'b0;
    case (o)
      2'b01: begin
        r  = ua - ub;
        rs = sa - sb;
        es = r[7:0];
        ec = (ua >= ub);
        ev = (rs > 127) || (rs < -128);
      end
      2'b11: acc_m[s] = 8'h00;
      default: begin
        r  = ua + ub;
        rs = sa + sb;
        es = r[7:0];
        ec = (r > 255);
        ev = (rs > 127) || (rs < -128);
        if (o == 2'b10) acc_m[s] = es;
      end
    endcase
    ez = (es == 8'h00);
  endtask

  task automatic issue(input bit s, input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv);
    int guard;
    guard = 0;
    @(negedge clk);
    sel = s;
    #1;
    while (!obs_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready before issue", obs_in_ready, 1);
    in_valid = 1'b1;
    op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!obs_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!obs_out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid timeout: got 0 expected 1");
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " out_valid after take"}, obs_out_valid, 0);
    chk({name, " busy after take"}, obs_busy, 0);
    chk({name, " in_ready after take"}, obs_in_ready, 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] es;
    logic ec, ev, ez;
    string nm;

    vt[0]  = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{2'b01, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{2'b11, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{2'b10, 8'h33, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{2'b10, 8'h00, 8'h50, 8'hA0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{2'b10, 8'hFF, 8'h50, 8'hF0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{2'b10, 8'h11, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[10] = '{2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    op = 2'b00; a = 8'h00; b = 8'h00;
    acc_m[0] = 8'h00; acc_m[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      nm = $sformatf("reset d%0d", s);
      chk({nm, " sum"}, obs_sum, 0);
      chk({nm, " cout"}, obs_cout, 0);
      chk({nm, " ovf"}, obs_ovf, 0);
      chk({nm, " zero"}, obs_zero, 0);
      chk({nm, " out_valid"}, obs_out_valid, 0);
      chk({nm, " busy"}, obs_busy, 0);
      chk({nm, " in_ready"}, obs_in_ready, 1);
    end

    // Vector table on both instances; latency is WIDTH/DIGIT for serial ops.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NV; i++) begin
        nm = $sformatf("vec%0d d%0d", i, s);
        issue(bit'(s), vt[i].op, vt[i].a, vt[i].b);
        wait_result(lat);
        chk({nm, " sum"}, obs_sum, vt[i].sum);
        chk({nm, " cout"}, obs_cout, vt[i].c);
        chk({nm, " ovf"}, obs_ovf, vt[i].v);
        chk({nm, " zero"}, obs_zero, vt[i].z);
        if (vt[i].op != 2'b11) chk({nm, " latency"}, lat, (s == 0) ? 8 : 2);
        consume(nm);
      end
    end

    // Reset in the middle of RUN clears everything, accumulator included.
    issue(1'b0, 2'b00, 8'h55, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    chk("midrun busy before reset", obs_busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun reset busy", obs_busy, 0);
    chk("midrun reset out_valid", obs_out_valid, 0);
    chk("midrun reset sum", obs_sum, 0);
    chk("midrun reset cout", obs_cout, 0);
    chk("midrun reset ovf", obs_ovf, 0);
    chk("midrun reset zero", obs_zero, 0);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      nm = $sformatf("acc after reset d%0d", s);
      issue(bit'(s), 2'b10, 8'h77, 8'h00);
      wait_result(lat);
      chk({nm, " sum"}, obs_sum, 0);
      chk({nm, " zero"}, obs_zero, 1);
      consume(nm);
    end
    acc_m[0] = 8'h00; acc_m[1] = 8'h00;

    // ena low for 4 cycles mid-RUN stretches latency by exactly 4.
    issue(1'b0, 2'b00, 8'h7F, 8'h01);
    repeat (3) begin @(posedge clk); #1; end
    ena = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("freeze in_ready", obs_in_ready, 0);
      chk("freeze busy", obs_busy, 1);
      chk("freeze out_valid", obs_out_valid, 0);
    end
    ena = 1'b1;
    wait_result(lat);
    chk("freeze total latency", 7 + lat, 12);
    chk("freeze sum", obs_sum, 8'h80);
    chk("freeze ovf", obs_ovf, 1);
    chk("freeze cout", obs_cout, 0);
    consume("freeze");

    // Result held while the consumer stalls, and while ena is low.
    issue(1'b0, 2'b00, 8'h12, 8'h34);
    wait_result(lat);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall sum", obs_sum, 8'h46);
      chk("stall flags", {obs_cout, obs_ovf, obs_zero}, 3'b000);
      chk("stall out_valid", obs_out_valid, 1);
      chk("stall in_ready", obs_in_ready, 0);
      chk("stall busy", obs_busy, 1);
    end
    ena = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("ena low blocks take", obs_out_valid, 1);
    end
    ena = 1'b1;
    consume("stall");

    // Random operations on both instances against the reference model.
    for (int i = 0; i < 150; i++) begin
      bit s;
      logic [1:0] o;
      logic [7:0] av, bv;
      int dly;
      s   = bit'($urandom_range(0, 1));
      o   = 2'($urandom_range(0, 3));
      av  = 8'($urandom);
      bv  = 8'($urandom);
      dly = $urandom_range(0, 2);
      model(int'(s), o, av, bv, es, ec, ev, ez);
      nm = $sformatf("rand%0d d%0d op%0d %h,%h", i, s, o, av, bv);
      issue(s, o, av, bv);
      wait_result(lat);
      if (o != 2'b11) chk({nm, " latency"}, lat, s ? 2 : 8);
      repeat (dly) begin @(posedge clk); #1; end
      chk({nm, " sum"}, obs_sum, es);
      chk({nm, " cout"}, obs_cout, ec);
      chk({nm, " ovf"}, obs_ovf, ev);
      chk({nm, " zero"}, obs_zero, ez);
      consume(nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
